// File: rtl/accum_32bit.sv
// accum_32bit -- frame accumulator with carry and beat statistics.
//
// Sums every accepted 32-bit beat of a frame (modulo 2^32), counts the beats
// whose addition carried out of bit 32, and counts beats in the frame. The
// frame result is presented on out_* with a valid/ready handshake. No new
// beat is taken while a result is held, so frames never overlap.
//
// Ports
//   clk            sole clock, rising edge
//   rst_n          asynchronous active-low reset
//   in_valid       upstream presents in_data
//   in_ready       a beat is accepted this cycle when in_valid is also high
//   in_data        operand added to the running sum
//   in_last        final beat of a frame (only meaningful with in_valid)
//   out_valid      frame result held on out_*
//   out_ready      downstream takes the result
//   out_sum        frame sum modulo 2^32
//   out_carry_cnt  beats whose addition carried out (saturating)
//   out_carry_sat  a carry arrived while out_carry_cnt was already all-ones
//   out_beats      beats in the frame (saturating)

// adder_32bit -- 32-bit unsigned adder with carry out.
//   a, b  operands; s  sum modulo 2^32; c32  carry out of bit 32
module adder_32bit (
    input  logic [32:1] a,
    input  logic [32:1] b,
    output logic [32:1] s,
    output logic        c32
);
    assign {c32, s} = {1'b0, a} + {1'b0, b};
endmodule

// state | meaning
// IDLE  | no beat of the current frame yet; running sum treated as 0
// ACC   | mid-frame, accumulating beats
// HOLD  | result presented, waiting for out_ready; input stalled
module accum_32bit #(
    parameter int CNT_W = 8,
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [32:1]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [32:1]      out_sum,
    output logic [CNT_W-1:0] out_carry_cnt,
    output logic             out_carry_sat,
    output logic [LEN_W-1:0] out_beats
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             live_q;
    logic [32:1]      sum_q;
    logic [CNT_W-1:0] cnt_q;
    logic             sat_q;
    logic [LEN_W-1:0] beats_q;

    logic [32:1]      add_a;
    logic [32:1]      add_s;
    logic             add_c32;
    logic             accept;
    logic             release_hold;

    // live_q keeps in_ready low while reset is asserted and raises it on the
    // first edge after release.
    assign in_ready     = live_q && (state_q != HOLD);
    assign out_valid    = (state_q == HOLD);
    assign accept       = in_valid && in_ready;
    assign release_hold = (state_q == HOLD) && out_ready;

    assign add_a = (state_q == IDLE) ? '0 : sum_q;

    adder_32bit u_adder (
        .a   (add_a),
        .b   (in_data),
        .s   (add_s),
        .c32 (add_c32)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = in_last ? HOLD : ACC;
                end
            end
            ACC: begin
                if (accept && in_last) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            live_q  <= 1'b0;
            sum_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            beats_q <= '0;
        end else begin
            state_q <= state_d;
            live_q  <= 1'b1;
            if (release_hold) begin
                sum_q   <= '0;
                cnt_q   <= '0;
                sat_q   <= 1'b0;
                beats_q <= '0;
            end else if (accept) begin
                sum_q <= add_s;
                if (add_c32) begin
                    if (&cnt_q) begin
                        sat_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                if (!(&beats_q)) begin
                    beats_q <= beats_q + LEN_W'(1);
                end
            end
        end
    end

    assign out_sum       = sum_q;
    assign out_carry_cnt = cnt_q;
    assign out_carry_sat = sat_q;
    assign out_beats     = beats_q;

endmodule

// File: tb/tb_accum_32bit.sv
module tb_accum_32bit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_last;
    logic        out_ready;

    // u_a: default widths; u_b: CNT_W=2, LEN_W=3 for saturation cases.
    logic        a_in_ready, a_out_valid, a_sat;
    logic [31:0] a_sum;
    logic [7:0]  a_cnt;
    logic [15:0] a_beats;

    logic        b_in_ready, b_out_valid, b_sat;
    logic [31:0] b_sum;
    logic [1:0]  b_cnt;
    logic [2:0]  b_beats;

    int n_cmp;
    int n_bad;

    accum_32bit u_a (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (a_in_ready),
        .in_data       (in_data),
        .in_last       (in_last),
        .out_valid     (a_out_valid),
        .out_ready     (out_ready),
        .out_sum       (a_sum),
        .out_carry_cnt (a_cnt),
        .out_carry_sat (a_sat),
        .out_beats     (a_beats)
    );

    accum_32bit #(.CNT_W(2), .LEN_W(3)) u_b (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (b_in_ready),
        .in_data       (in_data),
        .in_last       (in_last),
        .out_valid     (b_out_valid),
        .out_ready     (out_ready),
        .out_sum       (b_sum),
        .out_carry_cnt (b_cnt),
        .out_carry_sat (b_sat),
        .out_beats     (b_beats)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One beat: present it, expect in_ready, take the edge, sample after it.
    task automatic beat(input logic [31:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        n_cmp++;
        if (a_in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL beat_ready: in_ready=%b required 1", a_in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        n_cmp++;
        if ({a_out_valid, a_in_ready, a_sum, a_cnt, a_sat, a_beats} !==
            {1'b0, 1'b1, 32'h0, 8'h0, 1'b0, 16'h0}) begin
            n_bad++;
            $display("FAIL drain: valid=%b ready=%b sum=%h cnt=%0d sat=%b beats=%0d required 0 1 0 0 0 0",
                     a_out_valid, a_in_ready, a_sum, a_cnt, a_sat, a_beats);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        #3;
        n_cmp++;
        if ({a_in_ready, a_out_valid, a_sum, a_cnt, a_sat, a_beats} !== '0) begin
            n_bad++;
            $display("FAIL reset_state: ready=%b valid=%b sum=%h cnt=%0d sat=%b beats=%0d required all 0",
                     a_in_ready, a_out_valid, a_sum, a_cnt, a_sat, a_beats);
        end
        @(posedge clk); @(posedge clk);
        #2 rst_n = 1'b1;
        n_cmp++;
        if (a_in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL ready_before_edge: in_ready=%b required 0", a_in_ready);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (a_in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL ready_after_edge: in_ready=%b required 1", a_in_ready);
        end
    endtask

    task automatic test_three_beat();
        beat(32'd1, 1'b0);
        beat(32'd2, 1'b0);
        n_cmp++;
        if (a_out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL early_valid: out_valid=%b required 0", a_out_valid);
        end
        beat(32'd3, 1'b1);
        n_cmp++;
        if ({a_out_valid, a_sum, a_cnt, a_sat, a_beats} !== {1'b1, 32'd6, 8'd0, 1'b0, 16'd3}) begin
            n_bad++;
            $display("FAIL frame_123: valid=%b sum=%h cnt=%0d sat=%b beats=%0d required 1 6 0 0 3",
                     a_out_valid, a_sum, a_cnt, a_sat, a_beats);
        end
        drain();
    endtask

    task automatic test_carry();
        beat(32'hFFFF_FFFF, 1'b0);
        beat(32'h0000_0002, 1'b1);
        n_cmp++;
        if ({a_out_valid, a_sum, a_cnt, a_sat, a_beats} !== {1'b1, 32'h1, 8'd1, 1'b0, 16'd2}) begin
            n_bad++;
            $display("FAIL carry_one: valid=%b sum=%h cnt=%0d sat=%b beats=%0d required 1 1 1 0 2",
                     a_out_valid, a_sum, a_cnt, a_sat, a_beats);
        end
        drain();
    endtask

    task automatic test_msb_beats();
        // 5 x 2^31 = 2^33 + 2^31: two carries, no saturation even at CNT_W=2.
        for (int i = 0; i < 5; i++) beat(32'h8000_0000, (i == 4));
        n_cmp++;
        if ({a_sum, a_cnt, a_sat, a_beats} !== {32'h8000_0000, 8'd2, 1'b0, 16'd5}) begin
            n_bad++;
            $display("FAIL msb_a: sum=%h cnt=%0d sat=%b beats=%0d required 80000000 2 0 5",
                     a_sum, a_cnt, a_sat, a_beats);
        end
        n_cmp++;
        if ({b_out_valid, b_sum, b_cnt, b_sat, b_beats} !== {1'b1, 32'h8000_0000, 2'd2, 1'b0, 3'd5}) begin
            n_bad++;
            $display("FAIL msb_b: valid=%b sum=%h cnt=%0d sat=%b beats=%0d required 1 80000000 2 0 5",
                     b_out_valid, b_sum, b_cnt, b_sat, b_beats);
        end
        drain();
    endtask

    task automatic test_carry_sat();
        // Beats 2..5 each carry: 4 carries; sum = 5*FFFFFFFF mod 2^32 = FFFFFFFB.
        for (int i = 0; i < 5; i++) beat(32'hFFFF_FFFF, (i == 4));
        n_cmp++;
        if ({a_sum, a_cnt, a_sat, a_beats} !== {32'hFFFF_FFFB, 8'd4, 1'b0, 16'd5}) begin
            n_bad++;
            $display("FAIL sat_a: sum=%h cnt=%0d sat=%b beats=%0d required fffffffb 4 0 5",
                     a_sum, a_cnt, a_sat, a_beats);
        end
        n_cmp++;
        if ({b_sum, b_cnt, b_sat, b_beats} !== {32'hFFFF_FFFB, 2'd3, 1'b1, 3'd5}) begin
            n_bad++;
            $display("FAIL sat_b: sum=%h cnt=%0d sat=%b beats=%0d required fffffffb 3 1 5",
                     b_sum, b_cnt, b_sat, b_beats);
        end
        drain();
        n_cmp++;
        if ({b_cnt, b_sat} !== {2'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL sat_clear: cnt=%0d sat=%b required 0 0", b_cnt, b_sat);
        end
    endtask

    task automatic test_beat_sat();
        for (int i = 0; i < 9; i++) beat(32'd1, (i == 8));
        n_cmp++;
        if ({a_sum, a_beats, b_sum, b_beats} !== {32'd9, 16'd9, 32'd9, 3'd7}) begin
            n_bad++;
            $display("FAIL beat_sat: a_sum=%0d a_beats=%0d b_sum=%0d b_beats=%0d required 9 9 9 7",
                     a_sum, a_beats, b_sum, b_beats);
        end
        drain();
    endtask

    task automatic test_single_beat();
        beat(32'h1234_5678, 1'b1);
        n_cmp++;
        if ({a_out_valid, a_sum, a_cnt, a_beats} !== {1'b1, 32'h1234_5678, 8'd0, 16'd1}) begin
            n_bad++;
            $display("FAIL single: valid=%b sum=%h cnt=%0d beats=%0d required 1 12345678 0 1",
                     a_out_valid, a_sum, a_cnt, a_beats);
        end
        drain();
    endtask

    task automatic test_idle_last();
        beat(32'd1, 1'b0);
        in_valid = 1'b0;
        in_last  = 1'b1;
        in_data  = 32'd50;
        repeat (3) @(posedge clk);
        #1;
        in_last = 1'b0;
        n_cmp++;
        if ({a_out_valid, a_sum, a_beats} !== {1'b0, 32'd1, 16'd1}) begin
            n_bad++;
            $display("FAIL idle_last: valid=%b sum=%0d beats=%0d required 0 1 1",
                     a_out_valid, a_sum, a_beats);
        end
        beat(32'd4, 1'b1);
        n_cmp++;
        if ({a_out_valid, a_sum, a_beats} !== {1'b1, 32'd5, 16'd2}) begin
            n_bad++;
            $display("FAIL gap_frame: valid=%b sum=%0d beats=%0d required 1 5 2",
                     a_out_valid, a_sum, a_beats);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        int bad_hold;
        beat(32'd7, 1'b1);
        in_valid = 1'b1;
        in_data  = 32'h0000_000A;
        in_last  = 1'b1;
        bad_hold = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if ({a_in_ready, a_out_valid, a_sum, a_cnt, a_beats} !== {1'b0, 1'b1, 32'd7, 8'd0, 16'd1})
                bad_hold++;
        end
        n_cmp++;
        if (bad_hold != 0) begin
            n_bad++;
            $display("FAIL hold_stable: %0d unstable cycles required 0", bad_hold);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        n_cmp++;
        if ({a_out_valid, a_in_ready} !== 2'b01) begin
            n_bad++;
            $display("FAIL no_bubble: valid=%b ready=%b required 0 1", a_out_valid, a_in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        n_cmp++;
        if ({a_out_valid, a_sum, a_beats} !== {1'b1, 32'hA, 16'd1}) begin
            n_bad++;
            $display("FAIL next_frame: valid=%b sum=%h beats=%0d required 1 a 1",
                     a_out_valid, a_sum, a_beats);
        end
        drain();
    endtask

    task automatic test_mid_reset();
        beat(32'd1, 1'b0);
        beat(32'd2, 1'b0);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({a_in_ready, a_out_valid, a_sum, a_cnt, a_sat, a_beats} !== '0) begin
            n_bad++;
            $display("FAIL mid_reset: ready=%b valid=%b sum=%h cnt=%0d sat=%b beats=%0d required all 0",
                     a_in_ready, a_out_valid, a_sum, a_cnt, a_sat, a_beats);
        end
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        beat(32'd5, 1'b1);
        n_cmp++;
        if ({a_out_valid, a_sum, a_beats} !== {1'b1, 32'd5, 16'd1}) begin
            n_bad++;
            $display("FAIL post_reset: valid=%b sum=%0d beats=%0d required 1 5 1",
                     a_out_valid, a_sum, a_beats);
        end
        // Reset while holding a result must drop it without a handshake.
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({a_out_valid, a_sum, a_beats} !== '0) begin
            n_bad++;
            $display("FAIL hold_reset: valid=%b sum=%0d beats=%0d required 0 0 0",
                     a_out_valid, a_sum, a_beats);
        end
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_three_beat();
        test_carry();
        test_msb_beats();
        test_carry_sat();
        test_beat_sat();
        test_single_beat();
        test_idle_last();
        test_back_to_back();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
